// File: rtl/rom_fetch_pkg.sv
// Shared types and helpers for the ROM fetch unit: FSM state encoding,
// the prefetch entry layout and the FIFO occupancy-counter width.
package rom_fetch_pkg;

  localparam int ENTRY_ADDR_W = 8;
  localparam int ENTRY_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DONE
  } fetch_state_e;

  typedef struct packed {
    logic [ENTRY_ADDR_W-1:0] addr;
    logic [ENTRY_DATA_W-1:0] data;
  } fetch_entry_t;

  // One extra bit over the pointer width so full and empty stay distinct.
  function automatic int fifo_cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// First-word-fall-through prefetch FIFO with synchronous flush; the head word
// is read straight from registered storage and forced to zero while empty.
module fetch_fifo
  import rom_fetch_pkg::*;
#(
  parameter int WIDTH = 40,
  parameter int DEPTH = 4,
  localparam int CW = fifo_cnt_width(DEPTH),
  localparam int PW = CW - 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rptr;
  logic [PW-1:0]    wptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count == '0);
  assign full_o  = (count == CW'(DEPTH));
  assign count_o = count;
  assign do_pop  = pop_i && !empty_o;
  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = empty_o ? '0 : mem[rptr];

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) begin
      mem[wptr] <= data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else if (flush_i) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        wptr <= wptr + 1'b1;
      end
      if (do_pop) begin
        rptr <= rptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (do_pop && !do_push) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/rom_fetch_unit.sv
// ROM fetch initiator: walks pc through the ROM into a prefetch FIFO and streams
// words to the core. Define ROM_FETCH_PERF_EN to add push/redirect counters.
module rom_fetch_unit
  import rom_fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    FIFO_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0,
  parameter logic [ADDR_WIDTH-1:0] LAST_ADDR  = '1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic                  redirect_i,
  input  logic [ADDR_WIDTH-1:0] redirect_addr_i,
  output logic [ADDR_WIDTH-1:0] rom_addr_o,
  input  logic [DATA_WIDTH-1:0] rom_data_i,
  output logic                  instr_valid_o,
  input  logic                  instr_ready_i,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [ADDR_WIDTH-1:0] instr_addr_o,
  output logic                  busy_o,
  output logic                  done_o
`ifdef ROM_FETCH_PERF_EN
  ,
  output logic [31:0]           fetch_count_o,
  output logic [15:0]           flush_count_o
`endif
);

  localparam int EW = ADDR_WIDTH + DATA_WIDTH;
  localparam int CW = fifo_cnt_width(FIFO_DEPTH);

  fetch_state_e          state_q;
  fetch_state_e          state_d;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] pc_d;
  logic                  push;
  logic                  flush;
  logic                  pop;
  logic                  push_ok;
  logic                  full;
  logic                  empty;
  logic [CW-1:0]         count;
  logic [EW-1:0]         head;

  assign pop           = instr_valid_o && instr_ready_i;
  assign push_ok       = !full || pop;
  assign instr_valid_o = !empty;
  assign {instr_addr_o, instr_o} = head;
  assign rom_addr_o    = pc_q;
  assign busy_o        = (state_q != IDLE);
  assign done_o        = (state_q == DONE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      pc_q    <= RESET_ADDR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Priority: redirect over stop over start; pc parks on LAST_ADDR in DONE.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push    = 1'b0;
    flush   = 1'b0;
    if (redirect_i) begin
      flush   = 1'b1;
      pc_d    = redirect_addr_i;
      state_d = FETCH;
    end else if (stop_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_d = FETCH;
          end
        end
        FETCH: begin
          if (push_ok) begin
            push = 1'b1;
            if (pc_q == LAST_ADDR) begin
              state_d = DONE;
            end else begin
              pc_d = pc_q + 1'b1;
            end
          end
        end
        DONE: begin
          state_d = DONE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .data_i  ({pc_q, rom_data_i}),
    .pop_i   (pop),
    .flush_i (flush),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  always_comb begin
    assert (empty == (count == '0));
    assert (full == (count == CW'(FIFO_DEPTH)));
  end

`ifdef ROM_FETCH_PERF_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_count_o <= '0;
      flush_count_o <= '0;
    end else begin
      if (push && (fetch_count_o != '1)) begin
        fetch_count_o <= fetch_count_o + 1'b1;
      end
      if (redirect_i && (flush_count_o != '1)) begin
        flush_count_o <= flush_count_o + 1'b1;
      end
    end
  end
`endif

endmodule
